// File: rtl/jump_charger_pkg.sv
// Shared types and constants for the jump charger: FSM encoding, default
// saturation level and a saturating increment helper.
package jump_charger_pkg;

  typedef enum logic [2:0] {
    StIdle        = 3'd0,
    StCharge      = 3'd1,
    StPad         = 3'd2,
    StCooldown    = 3'd3,
    StWaitRelease = 3'd4
  } state_e;

  localparam logic [7:0] DefaultMaxDist = 8'd60;

  // Saturating +1 that never exceeds lim and never wraps.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/jump_charger_btn_debounce.sv
// Two-flop synchroniser plus stability counter: clean follows btn only after
// DB_CYCLES consecutive synchronised samples disagree with it.
module btn_debounce
  import jump_charger_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic restart,
  input  logic btn,
  output logic clean
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q, clean_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (restart) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      if (sync2_q == clean_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        clean_q <= ~clean_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/jump_charger.sv
// Turns a debounced jump button into a ramping jump_dist stream with a minimum
// nonzero length, a post-jump cooldown and a lockout while the game is dead.
module jump_charger
  import jump_charger_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned STEP_DIV    = 4096,
  parameter logic [7:0]  MAX_DIST    = DefaultMaxDist,
  parameter int unsigned MIN_HOLD    = 8192,
  parameter int unsigned COOL_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       btn,
  input  logic       dead,
  output logic [7:0] jump_dist,
  output logic       charging,
  output logic       jump_valid,
  output logic [7:0] last_dist
);

  localparam int unsigned PreW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HoldW = $clog2(MIN_HOLD + 1) > 0 ? $clog2(MIN_HOLD + 1) : 1;
  localparam int unsigned CoolW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  localparam logic [PreW-1:0]  PreMax  = PreW'(STEP_DIV - 1);
  localparam logic [HoldW-1:0] HoldMin = HoldW'(MIN_HOLD);
  localparam logic [CoolW-1:0] CoolMax = CoolW'(COOL_CYCLES - 1);

  logic clean;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .restart(restart),
    .btn    (btn),
    .clean  (clean)
  );

  state_e           state_q, state_d;
  logic [7:0]       level_q, level_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CoolW-1:0] cool_q, cool_d;
  logic [7:0]       jump_dist_q, jump_dist_d;
  logic [7:0]       last_dist_q, last_dist_d;
  logic             charging_q, charging_d;
  logic             jump_valid_q, jump_valid_d;

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    presc_d      = presc_q;
    hold_d       = hold_q;
    cool_d       = cool_q;
    last_dist_d  = last_dist_q;
    jump_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A press seen while dead must be released before it can count.
        if (dead) begin
          if (clean) state_d = StWaitRelease;
        end else if (clean) begin
          state_d = StCharge;
          level_d = 8'd1;
          presc_d = '0;
          hold_d  = HoldW'(1);
        end
      end

      StCharge: begin
        if (dead) begin
          state_d = StWaitRelease;
        end else if (!clean) begin
          // Release beats a same-cycle prescaler wrap: level stays frozen.
          if (hold_q >= HoldMin) begin
            state_d      = StCooldown;
            jump_valid_d = 1'b1;
            last_dist_d  = level_q;
            cool_d       = '0;
          end else begin
            state_d = StPad;
            hold_d  = hold_q + 1'b1;
          end
        end else begin
          if (hold_q < HoldMin) hold_d = hold_q + 1'b1;
          if (presc_q == PreMax) begin
            presc_d = '0;
            level_d = sat_inc(level_q, MAX_DIST);
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      StPad: begin
        if (dead) begin
          state_d = StWaitRelease;
        end else if (hold_q >= HoldMin) begin
          state_d      = StCooldown;
          jump_valid_d = 1'b1;
          last_dist_d  = level_q;
          cool_d       = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      StCooldown: begin
        if (cool_q == CoolMax) begin
          state_d = clean ? StWaitRelease : StIdle;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end

      StWaitRelease: begin
        if (!clean) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    charging_d  = (state_d == StCharge) || (state_d == StPad);
    jump_dist_d = charging_d ? level_d : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q      <= StIdle;
      level_q      <= 8'd0;
      presc_q      <= '0;
      hold_q       <= '0;
      cool_q       <= '0;
      jump_dist_q  <= 8'd0;
      last_dist_q  <= 8'd0;
      charging_q   <= 1'b0;
      jump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      cool_q       <= cool_d;
      jump_dist_q  <= jump_dist_d;
      last_dist_q  <= last_dist_d;
      charging_q   <= charging_d;
      jump_valid_q <= jump_valid_d;
    end
  end

  assign jump_dist  = jump_dist_q;
  assign last_dist  = last_dist_q;
  assign charging   = charging_q;
  assign jump_valid = jump_valid_q;

endmodule

// File: tb/tb_jump_charger.sv
// Directed bench for jump_charger: table of press lengths plus hand-written
// reset, dead-abort and cooldown-lockout sequences.
module tb_jump_charger;

  localparam int unsigned DbCycles   = 4;
  localparam int unsigned StepDiv    = 8;
  localparam logic [7:0]  MaxDist    = 8'd10;
  localparam int unsigned MinHold    = 16;
  localparam int unsigned CoolCycles = 8;

  logic       clk = 1'b0;
  logic       restart, btn, dead;
  logic [7:0] jump_dist, last_dist;
  logic       charging, jump_valid;

  int checks = 0;
  int errors = 0;

  // Per-run observations.
  int s_first, s_len, s_last, s_max, s_chg, s_vcnt, s_vpos, s_ramp;

  always #5 clk = ~clk;

  jump_charger #(
    .DB_CYCLES  (DbCycles),
    .STEP_DIV   (StepDiv),
    .MAX_DIST   (MaxDist),
    .MIN_HOLD   (MinHold),
    .COOL_CYCLES(CoolCycles)
  ) dut (
    .clk       (clk),
    .restart   (restart),
    .btn       (btn),
    .dead      (dead),
    .jump_dist (jump_dist),
    .charging  (charging),
    .jump_valid(jump_valid),
    .last_dist (last_dist)
  );

  typedef struct {
    int hold;
    int window;
    int exp_first;
    int exp_len;
    int exp_final;
    int exp_valid;
    int exp_last;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    s_first = 0; s_len = 0; s_last = 0; s_max = 0;
    s_chg = 0; s_vcnt = 0; s_vpos = 0; s_ramp = 0;
  endtask

  // Expected level for the n-th nonzero sample when clean was high for hold cycles.
  function automatic int exp_level(input int n, input int hold);
    int k;
    int lvl;
    k   = (n < hold) ? n : hold;
    lvl = 1 + (k - 1) / int'(StepDiv);
    return (lvl > int'(MaxDist)) ? int'(MaxDist) : lvl;
  endfunction

  task automatic tick_sample(input int c, input int hold);
    @(negedge clk);
    if (jump_dist != 8'd0) begin
      if (s_len == 0) s_first = c;
      s_len++;
      if (hold > 0 && int'(jump_dist) != exp_level(s_len, hold)) s_ramp++;
      s_last = int'(jump_dist);
      if (int'(jump_dist) > s_max) s_max = int'(jump_dist);
    end
    if (charging) s_chg++;
    if (jump_valid) begin
      s_vcnt++;
      s_vpos = c;
      if (jump_dist != 8'd0) s_ramp++;
    end
  endtask

  // Press for hold cycles starting after the current edge, observe window cycles.
  task automatic run_press(input int hold, input int window);
    clear_stats();
    @(posedge clk);
    #1 btn = 1'b1;
    for (int c = 1; c <= window; c++) begin
      @(posedge clk);
      #1 if (c == hold) btn = 1'b0;
      tick_sample(c, hold);
    end
  endtask

  task automatic watch(input int cycles);
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk);
      tick_sample(c, 0);
    end
  endtask

  task automatic wait_level(input logic [7:0] lvl, input int budget);
    int k;
    k = 0;
    while (jump_dist != lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_for_level", int'(jump_dist == lvl), 1);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{hold: 40,  window: 100, exp_first: 7, exp_len: 40,  exp_final: 5,  exp_valid: 1,
                exp_last: 5};
    vecs[1] = '{hold: 10,  window: 60,  exp_first: 7, exp_len: 16,  exp_final: 2,  exp_valid: 1,
                exp_last: 2};
    vecs[2] = '{hold: 3,   window: 40,  exp_first: 0, exp_len: 0,   exp_final: 0,  exp_valid: 0,
                exp_last: 2};
    vecs[3] = '{hold: 200, window: 260, exp_first: 7, exp_len: 200, exp_final: 10, exp_valid: 1,
                exp_last: 10};

    restart = 1'b1;
    btn     = 1'b0;
    dead    = 1'b0;
    repeat (3) @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    check("reset_jump_dist", int'(jump_dist), 0);
    check("reset_charging", int'(charging), 0);
    check("reset_jump_valid", int'(jump_valid), 0);
    check("reset_last_dist", int'(last_dist), 0);
    check("reset_state", int'(dut.state_q), 0);

    foreach (vecs[i]) begin
      run_press(vecs[i].hold, vecs[i].window);
      check($sformatf("v%0d_first", i), s_first, vecs[i].exp_first);
      check($sformatf("v%0d_len", i), s_len, vecs[i].exp_len);
      check($sformatf("v%0d_final", i), s_last, vecs[i].exp_final);
      check($sformatf("v%0d_max", i), s_max, vecs[i].exp_final);
      check($sformatf("v%0d_charging", i), s_chg, vecs[i].exp_len);
      check($sformatf("v%0d_ramp", i), s_ramp, 0);
      check($sformatf("v%0d_valid_cnt", i), s_vcnt, vecs[i].exp_valid);
      check($sformatf("v%0d_valid_pos", i), s_vpos,
            (vecs[i].exp_valid != 0) ? vecs[i].exp_first + vecs[i].exp_len : 0);
      check($sformatf("v%0d_last_dist", i), int'(last_dist), vecs[i].exp_last);
    end

    // Reset in the middle of a charge.
    @(posedge clk);
    #1 btn = 1'b1;
    wait_level(8'd3, 100);
    restart = 1'b1;
    btn     = 1'b0;
    @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    check("rst_mid_jump_dist", int'(jump_dist), 0);
    check("rst_mid_charging", int'(charging), 0);
    check("rst_mid_jump_valid", int'(jump_valid), 0);
    check("rst_mid_last_dist", int'(last_dist), 0);
    check("rst_mid_state", int'(dut.state_q), 0);
    clear_stats();
    watch(30);
    check("rst_mid_after_len", s_len, 0);
    check("rst_mid_after_valid", s_vcnt, 0);

    // Dead abort at level 3, then a press held across dead falling.
    @(posedge clk);
    #1 btn = 1'b1;
    wait_level(8'd3, 100);
    dead = 1'b1;
    @(negedge clk);
    check("dead_abort_dist", int'(jump_dist), 0);
    check("dead_abort_valid", int'(jump_valid), 0);
    clear_stats();
    watch(10);
    @(posedge clk);
    #1 dead = 1'b0;
    watch(30);
    check("dead_held_len", s_len, 0);
    check("dead_held_valid", s_vcnt, 0);
    check("dead_last_dist", int'(last_dist), 0);
    @(posedge clk);
    #1 btn = 1'b0;
    watch(15);
    run_press(40, 100);
    check("dead_repress_len", s_len, 40);
    check("dead_repress_valid", s_vcnt, 1);
    check("dead_repress_last", int'(last_dist), 5);

    // Press during cooldown and hold past its end: must wait for release.
    begin
      int found;
      found = 0;
      @(posedge clk);
      #1 btn = 1'b1;
      for (int c = 1; c <= 60 && found == 0; c++) begin
        @(posedge clk);
        #1 if (c == 10) btn = 1'b0;
        @(negedge clk);
        if (jump_valid) found = 1;
      end
      check("cool_first_jump_done", found, 1);
      btn = 1'b1;
    end
    clear_stats();
    watch(40);
    @(posedge clk);
    #1 btn = 1'b0;
    watch(25);
    check("cool_lock_len", s_len, 0);
    check("cool_lock_valid", s_vcnt, 0);
    check("cool_lock_last", int'(last_dist), 2);
    run_press(10, 60);
    check("cool_after_len", s_len, 16);
    check("cool_after_valid", s_vcnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
